// File: rtl/traffic_light_fsm.sv
// Main-road / side-road traffic light sequencer.
// Moore machine: each phase lasts its programmed number of Tick_1Hz pulses.
// All lamp outputs are registered and are loaded together with the state register.
// An optional walk phase is inserted after main yellow when a pedestrian request is pending.
// A single extension of side green is granted when a side-road vehicle is present at expiry.
//
// State_Dbg encoding: 0 S_MG, 1 S_MY, 2 S_WALK, 3 S_SG, 4 S_SGX, 5 S_SY.
//
// Optional feature macro: REPROGRAM_EN
//   defined   : base/ext/yellow durations are run-time registers. Sync_Reprogram writes
//               Time_Value to the register chosen by Sel_Param and restarts the sequence in S_MG.
//   undefined : durations are the constant parameters. The reprogram ports are present but ignored.
module traffic_light_fsm #(
  parameter int TW     = 4,
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic          Tick_1Hz,
  input  logic          Sync_Sensor,
  input  logic          Sync_WalkReq,
  input  logic          Sync_Reprogram,
  input  logic [1:0]    Sel_Param,
  input  logic [TW-1:0] Time_Value,
  output logic [2:0]    Main_Light,
  output logic [2:0]    Side_Light,
  output logic          Walk,
  output logic [2:0]    State_Dbg
);

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MY   = 3'd1,
    S_WALK = 3'd2,
    S_SG   = 3'd3,
    S_SGX  = 3'd4,
    S_SY   = 3'd5
  } state_t;

  // Lamp patterns, {R,Y,G}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [TW-1:0] BASE_INIT = TW'(T_BASE);
  localparam logic [TW-1:0] EXT_INIT  = TW'(T_EXT);
  localparam logic [TW-1:0] YEL_INIT  = TW'(T_YEL);
  localparam logic [TW-1:0] ONE       = TW'(1);

  state_t        state;
  state_t        expiry_state;
  logic [TW-1:0] timer;
  logic [TW-1:0] expiry_dur;
  logic          walk_latch;

  logic [TW-1:0] base_dur;
  logic [TW-1:0] ext_dur;
  logic [TW-1:0] yel_dur;
  logic          reprog_hit;
  logic [TW-1:0] reprog_base;

  // Timer start value for a phase of 'dur' ticks; zero is treated as a one-tick phase.
  function automatic logic [TW-1:0] first_count(input logic [TW-1:0] dur);
    return (dur == '0) ? '0 : (dur - ONE);
  endfunction

  function automatic logic [2:0] main_lamp(input state_t s);
    case (s)
      S_MG:    return LAMP_GRN;
      S_MY:    return LAMP_YEL;
      default: return LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input state_t s);
    case (s)
      S_SG, S_SGX: return LAMP_GRN;
      S_SY:        return LAMP_YEL;
      default:     return LAMP_RED;
    endcase
  endfunction

`ifdef REPROGRAM_EN
  logic [TW-1:0] base_q;
  logic [TW-1:0] ext_q;
  logic [TW-1:0] yel_q;

  assign reprog_hit  = Sync_Reprogram;
  assign reprog_base = (Sel_Param == 2'b00) ? Time_Value : base_q;
  assign base_dur    = base_q;
  assign ext_dur     = ext_q;
  assign yel_dur     = yel_q;

  // Duration registers, written by a reprogram cycle and restored to defaults on reset
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      base_q <= BASE_INIT;
      ext_q  <= EXT_INIT;
      yel_q  <= YEL_INIT;
    end else if (Sync_Reprogram) begin
      case (Sel_Param)
        2'b00:   base_q <= Time_Value;
        2'b01:   ext_q  <= Time_Value;
        2'b10:   yel_q  <= Time_Value;
        default: ;
      endcase
    end
  end
`else
  assign reprog_hit  = 1'b0;
  assign reprog_base = BASE_INIT;
  assign base_dur    = BASE_INIT;
  assign ext_dur     = EXT_INIT;
  assign yel_dur     = YEL_INIT;

  logic unused_reprog;
  assign unused_reprog = &{1'b0, Sync_Reprogram, Sel_Param, Time_Value};
`endif

  // Phase that follows the current one when its timer expires, and that phase's duration
  always_comb begin
    expiry_state = state;
    case (state)
      S_MG:    expiry_state = S_MY;
      S_MY:    expiry_state = walk_latch ? S_WALK : S_SG;
      S_WALK:  expiry_state = S_SG;
      S_SG:    expiry_state = Sync_Sensor ? S_SGX : S_SY;
      S_SGX:   expiry_state = S_SY;
      S_SY:    expiry_state = S_MG;
      default: expiry_state = S_MG;
    endcase

    expiry_dur = base_dur;
    case (expiry_state)
      S_MG, S_SG:    expiry_dur = base_dur;
      S_MY, S_SY:    expiry_dur = yel_dur;
      S_WALK, S_SGX: expiry_dur = ext_dur;
      default:       expiry_dur = base_dur;
    endcase
  end

  // Phase sequencer: state, phase timer, pedestrian latch and registered lamp outputs
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_MG;
      timer      <= first_count(BASE_INIT);
      walk_latch <= 1'b0;
      Main_Light <= LAMP_GRN;
      Side_Light <= LAMP_RED;
      Walk       <= 1'b0;
    end else if (reprog_hit) begin
      state      <= S_MG;
      timer      <= first_count(reprog_base);
      walk_latch <= 1'b0;
      Main_Light <= LAMP_GRN;
      Side_Light <= LAMP_RED;
      Walk       <= 1'b0;
    end else begin
      walk_latch <= walk_latch | Sync_WalkReq;
      if (Tick_1Hz) begin
        if (timer == '0) begin
          state      <= expiry_state;
          timer      <= first_count(expiry_dur);
          Main_Light <= main_lamp(expiry_state);
          Side_Light <= side_lamp(expiry_state);
          Walk       <= (expiry_state == S_WALK);
          if (expiry_state == S_WALK) begin
            walk_latch <= 1'b0;
          end
        end else begin
          timer <= timer - ONE;
        end
      end
    end
  end

  assign State_Dbg = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Testbench for traffic_light_fsm.
// A fixed vector table, hand-written phase-length sequences and a randomized run,
// all compared against a reference model that tracks phase, ticks elapsed and pending walk.
// Reprogram sequences follow REPROGRAM_EN in the same way as the design.
module tb_traffic_light_fsm;

  localparam int TW = 4;
  localparam int P_MG = 0, P_MY = 1, P_WALK = 2, P_SG = 3, P_SGX = 4, P_SY = 5;

  logic          clk = 1'b0;
  logic          Reset_n;
  logic          Tick_1Hz;
  logic          Sync_Sensor;
  logic          Sync_WalkReq;
  logic          Sync_Reprogram;
  logic [1:0]    Sel_Param;
  logic [TW-1:0] Time_Value;
  logic [2:0]    Main_Light;
  logic [2:0]    Side_Light;
  logic          Walk;
  logic [2:0]    State_Dbg;

  int checks = 0;
  int errors = 0;

  // Reference model
  int m_phase, m_elapsed, m_tb, m_te, m_ty;
  bit m_req;
  int tick_phase;

  const int main_exp[6] = '{1, 2, 4, 4, 4, 4};
  const int side_exp[6] = '{4, 4, 4, 1, 1, 2};
  const int walk_exp[6] = '{0, 0, 1, 0, 0, 0};

  typedef struct {
    bit       tick;
    bit       sensor;
    bit       walk;
    bit [2:0] exp_state;
    bit [2:0] exp_main;
    bit [2:0] exp_side;
    bit       exp_walk;
  } vec_t;

  vec_t vecs[$];

  traffic_light_fsm #(.TW(TW), .T_BASE(6), .T_EXT(3), .T_YEL(2)) dut (
    .clk            (clk),
    .Reset_n        (Reset_n),
    .Tick_1Hz       (Tick_1Hz),
    .Sync_Sensor    (Sync_Sensor),
    .Sync_WalkReq   (Sync_WalkReq),
    .Sync_Reprogram (Sync_Reprogram),
    .Sel_Param      (Sel_Param),
    .Time_Value     (Time_Value),
    .Main_Light     (Main_Light),
    .Side_Light     (Side_Light),
    .Walk           (Walk),
    .State_Dbg      (State_Dbg)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int phase_len(input int p);
    if (p == P_MG || p == P_SG) return m_tb;
    if (p == P_MY || p == P_SY) return m_ty;
    return m_te;
  endfunction

  task automatic model_reset();
    m_phase = P_MG; m_elapsed = 0; m_req = 1'b0;
    m_tb = 6; m_te = 3; m_ty = 2;
  endtask

  task automatic model_step(input bit tick, input bit sensor, input bit walk,
                            input bit reprog, input bit [1:0] sel, input int val);
    bit req_next;
`ifdef REPROGRAM_EN
    if (reprog) begin
      case (sel)
        2'd0: m_tb = val;
        2'd1: m_te = val;
        2'd2: m_ty = val;
        default: ;
      endcase
      m_phase = P_MG; m_elapsed = 0; m_req = 1'b0;
      return;
    end
`else
    bit unused_args;
    unused_args = reprog ^ sel[0] ^ (val == 0);
`endif
    req_next = m_req | walk;
    if (tick) begin
      m_elapsed++;
      if (m_elapsed >= eff(phase_len(m_phase))) begin
        case (m_phase)
          P_MG:    m_phase = P_MY;
          P_MY:    m_phase = m_req ? P_WALK : P_SG;
          P_WALK:  m_phase = P_SG;
          P_SG:    m_phase = sensor ? P_SGX : P_SY;
          P_SGX:   m_phase = P_SY;
          default: m_phase = P_MG;
        endcase
        m_elapsed = 0;
        if (m_phase == P_WALK) req_next = 1'b0;
      end
    end
    m_req = req_next;
  endtask

  task automatic checkOutput();
    check("state", State_Dbg, m_phase);
    check("main", Main_Light, main_exp[m_phase]);
    check("side", Side_Light, side_exp[m_phase]);
    check("walk", Walk, walk_exp[m_phase]);
    check("exclusive", (Main_Light[1:0] != 2'b00) && (Side_Light[1:0] != 2'b00), 0);
    check("onehot", ($countones(Main_Light) == 1) && ($countones(Side_Light) == 1), 1);
  endtask

  task automatic applyStimulus(input bit tick, input bit sensor, input bit walk,
                               input bit reprog, input bit [1:0] sel, input int val);
    @(negedge clk);
    Tick_1Hz = tick; Sync_Sensor = sensor; Sync_WalkReq = walk;
    Sync_Reprogram = reprog; Sel_Param = sel; Time_Value = val[TW-1:0];
    @(posedge clk);
    model_step(tick, sensor, walk, reprog, sel, val);
    #1;
    checkOutput();
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; Tick_1Hz = 1'b0; Sync_Sensor = 1'b0; Sync_WalkReq = 1'b0;
    Sync_Reprogram = 1'b0; Sel_Param = 2'b11; Time_Value = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    Reset_n = 1'b1;
    model_reset();
    tick_phase = 0;
    check("reset state", State_Dbg, P_MG);
    check("reset main", Main_Light, 3'b001);
    check("reset side", Side_Light, 3'b100);
    check("reset walk", Walk, 0);
  endtask

  // Runs with a tick every 4 clocks until the DUT leaves exp_state, checking the tick count
  task automatic expect_phase(input int exp_state, input int exp_ticks, input bit sensor,
                              input string name);
    int ticks = 0;
    int budget = 0;
    bit t;
    check({name, " entry"}, State_Dbg, exp_state);
    while (State_Dbg == exp_state && budget < 400) begin
      t = (tick_phase == 3);
      tick_phase = (tick_phase + 1) % 4;
      applyStimulus(t, sensor, 1'b0, 1'b0, 2'b11, 0);
      if (t) ticks++;
      budget++;
    end
    check({name, " exit"}, State_Dbg != exp_state, 1);
    check({name, " ticks"}, ticks, exp_ticks);
  endtask

  function automatic vec_t mk(input bit t, input bit s, input bit w, input int st);
    vec_t v;
    v.tick = t; v.sensor = s; v.walk = w;
    v.exp_state = st[2:0];
    v.exp_main  = main_exp[st][2:0];
    v.exp_side  = side_exp[st][2:0];
    v.exp_walk  = walk_exp[st][0];
    return v;
  endfunction

  initial begin
    model_reset();
    tick_phase = 0;

    // Table: tick every cycle from reset through walk, sensor extension and back to MG
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 0, P_MG));
    vecs.push_back(mk(1, 0, 0, P_MY));
    vecs.push_back(mk(1, 0, 1, P_MY));
    vecs.push_back(mk(1, 0, 0, P_WALK));
    vecs.push_back(mk(1, 0, 0, P_WALK));
    vecs.push_back(mk(1, 0, 0, P_WALK));
    vecs.push_back(mk(1, 0, 0, P_SG));
    vecs.push_back(mk(0, 1, 0, P_SG));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 0, P_SG));
    vecs.push_back(mk(1, 1, 0, P_SGX));
    vecs.push_back(mk(1, 1, 0, P_SGX));
    vecs.push_back(mk(1, 1, 0, P_SGX));
    vecs.push_back(mk(1, 1, 0, P_SY));
    vecs.push_back(mk(1, 0, 0, P_SY));
    vecs.push_back(mk(1, 0, 0, P_MG));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].tick, vecs[i].sensor, vecs[i].walk, 1'b0, 2'b11, 0);
      check($sformatf("vec%0d state", i), State_Dbg, vecs[i].exp_state);
      check($sformatf("vec%0d main", i), Main_Light, vecs[i].exp_main);
      check($sformatf("vec%0d side", i), Side_Light, vecs[i].exp_side);
      check($sformatf("vec%0d walk", i), Walk, vecs[i].exp_walk);
    end

    // Plain cycle, no requests
    $display("[TB] plain cycle");
    do_reset();
    expect_phase(P_MG, 6, 0, "t1 MG");
    expect_phase(P_MY, 2, 0, "t1 MY");
    expect_phase(P_SG, 6, 0, "t1 SG");
    expect_phase(P_SY, 2, 0, "t1 SY");
    check("t1 back to MG", State_Dbg, P_MG);

    // Sensor held: one extension only
    $display("[TB] sensor extension");
    do_reset();
    expect_phase(P_MG, 6, 1, "t2 MG");
    expect_phase(P_MY, 2, 1, "t2 MY");
    expect_phase(P_SG, 6, 1, "t2 SG");
    expect_phase(P_SGX, 3, 1, "t2 SGX");
    check("t2 SY after SGX", State_Dbg, P_SY);

    // Walk pulse in MG gives one walk phase
    $display("[TB] walk pulse");
    do_reset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 0);
    expect_phase(P_MG, 6, 0, "t3 MG");
    expect_phase(P_MY, 2, 0, "t3 MY");
    expect_phase(P_WALK, 3, 0, "t3 WALK");
    expect_phase(P_SG, 6, 0, "t3 SG");
    expect_phase(P_SY, 2, 0, "t3 SY");
    expect_phase(P_MG, 6, 0, "t3 MG2");
    expect_phase(P_MY, 2, 0, "t3 MY2");
    check("t3 no second walk", State_Dbg, P_SG);

    // Request on the walk-entry edge is consumed
    $display("[TB] walk request on entry edge");
    do_reset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 0);
    expect_phase(P_MG, 6, 0, "t4a MG");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 0);
    check("t4a walk entered", State_Dbg, P_WALK);
    expect_phase(P_WALK, 3, 0, "t4a WALK");
    expect_phase(P_SG, 6, 0, "t4a SG");
    expect_phase(P_SY, 2, 0, "t4a SY");
    expect_phase(P_MG, 6, 0, "t4a MG2");
    expect_phase(P_MY, 2, 0, "t4a MY2");
    check("t4a no second walk", State_Dbg, P_SG);

    // Request during walk gives a walk in the following cycle
    $display("[TB] walk request during walk");
    do_reset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 0);
    expect_phase(P_MG, 6, 0, "t4b MG");
    expect_phase(P_MY, 2, 0, "t4b MY");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 0);
    expect_phase(P_WALK, 3, 0, "t4b WALK");
    expect_phase(P_SG, 6, 0, "t4b SG");
    expect_phase(P_SY, 2, 0, "t4b SY");
    expect_phase(P_MG, 6, 0, "t4b MG2");
    expect_phase(P_MY, 2, 0, "t4b MY2");
    check("t4b second walk", State_Dbg, P_WALK);

    // Reprogramming
    $display("[TB] reprogram");
    do_reset();
    expect_phase(P_MG, 6, 0, "t5 MG");
    expect_phase(P_MY, 2, 0, "t5 MY");
`ifdef REPROGRAM_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2);
    check("t5 jump to MG", State_Dbg, P_MG);
    expect_phase(P_MG, 2, 0, "t5 MG short");
    expect_phase(P_MY, 2, 0, "t5 MY2");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 0);
    expect_phase(P_MG, 1, 0, "t5 MG zero");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3);
    check("t5 held in MG", State_Dbg, P_MG);
    expect_phase(P_MG, 3, 0, "t5 MG held");
    expect_phase(P_MY, 2, 0, "t5 MY3");
    check("t5 held req cleared", State_Dbg, P_SG);
`else
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2);
    check("t5 ignored", State_Dbg, P_SG);
    expect_phase(P_SG, 6, 0, "t5 SG");
    expect_phase(P_SY, 2, 0, "t5 SY");
`endif

    // Asynchronous reset in the middle of side yellow
    $display("[TB] async reset");
    do_reset();
    expect_phase(P_MG, 6, 0, "t6 MG");
    expect_phase(P_MY, 2, 0, "t6 MY");
    expect_phase(P_SG, 6, 0, "t6 SG");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 0);
    @(negedge clk);
    Tick_1Hz = 1'b0; Sync_WalkReq = 1'b0; Sync_Reprogram = 1'b0;
    @(posedge clk);
    #2;
    check("t6 pre-reset", State_Dbg, P_SY);
    Reset_n = 1'b0;
    #1;
    check("t6 async state", State_Dbg, P_MG);
    check("t6 async main", Main_Light, 3'b001);
    check("t6 async side", Side_Light, 3'b100);
    check("t6 async walk", Walk, 0);
    do_reset();
    expect_phase(P_MG, 6, 0, "t6 MG after");

    // Randomized run against the model
    $display("[TB] random");
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                    2'($urandom_range(0, 3)), $urandom_range(0, 15));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
